// File: rtl/video_tpg.sv
// video_tpg: free-running video timing and test-pattern generator (bars, ramp, checker, solid)
module video_tpg #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 56,
  parameter int   H_SYNC   = 120,
  parameter int   H_BP     = 64,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 37,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] vdata,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // ramp and checker slice fixed bits, so counters are at least that wide
  localparam int HW = $clog2(H_TOTAL) < 8 ? 8 : $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL) < 6 ? 6 : $clog2(V_TOTAL);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW = $clog2(BAR_W + 1);
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [BW-1:0] bar_sub;
  logic [2:0]    bar_idx;
  logic [1:0]    pat;
  logic [23:0]   solid;
  logic          h_last, v_last, bar_end, active, in_hs, in_vs;
  logic [23:0]   bars, pix;
  assign h_last  = h_cnt == HW'(H_TOTAL - 1);
  assign v_last  = v_cnt == VW'(V_TOTAL - 1);
  assign bar_end = bar_sub == BW'(BAR_W - 1);
  assign active  = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign in_hs   = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign in_vs   = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
  // bar colours fall out of the index bits: R off for 2,3,6,7; G off for 4..7; B off for odd bars
  assign bars = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
  // pixel colour for the current counter position from the frame-stable shadow pattern
  always_comb begin
    pix = pat == 2'd0 ? bars :
          pat == 2'd1 ? {3{h_cnt[7:0]}} :
          pat == 2'd2 ? {24{h_cnt[5] ^ v_cnt[5]}} : solid;
  end
  // raster counters, divider-free bar tracker and frame-boundary pattern capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_sub <= '0;
      bar_idx <= '0;
      pat     <= '0;
      solid   <= '0;
    end else begin
      h_cnt   <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      bar_sub <= (h_last || bar_end) ? '0 : bar_sub + BW'(1);
      bar_idx <= h_last ? '0 : bar_end ? bar_idx + 3'd1 : bar_idx;
      if (h_last && v_last) begin
        pat   <= pattern_sel;
        solid <= solid_rgb;
      end
    end
  end
  // all outputs registered together so they stay mutually aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vdata       <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else begin
      vdata       <= active ? pix : '0;
      de          <= active;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      hsync       <= in_hs ? HS_POL : ~HS_POL;
      vsync       <= in_vs ? VS_POL : ~VS_POL;
    end
  end
endmodule
